pot_scan_sequencer: RTL and testbench
=====================================

Name: pot_scan_sequencer

Overview:
- Round-robin scheduler for the shared ADC128S slide-pot A2D.
- Sequences one SPI conversion per channel through the A2D interface handshake (strt_cnv / cnv_cmplt) and latches each 12-bit result into a per-band gain register.
- Bands: LP, B1, B2, B3, HP, plus volume.
- Sits between the A2D interface and the band-gain/volume inputs of the equalizer engine; the filters never touch the A2D directly.

Parameters:
- SCAN_GAP, 1024, idle clk cycles between the end of one conversion and the next strt_cnv.
- TIMEOUT, 4096, clk cycles allowed for cnv_cmplt after strt_cnv before the slot is abandoned.
- DEADBAND, 8, minimum abs(new-old) LSBs that updates a register (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scanning enable; 0 holds in IDLE after the current slot completes
- strt_cnv  out  1  one-cycle pulse to the A2D interface to start a conversion
- chnnl  out  3  ADC channel for the conversion, stable from strt_cnv until cnv_cmplt
- cnv_cmplt  in  1  one-cycle pulse from the A2D interface, result valid
- res  in  12  conversion result, sampled on the cnv_cmplt cycle
- lp_gain, b1_gain, b2_gain, b3_gain, hp_gain  out  12 each  band gains
- volume  out  12  output volume
- scan_done  out  1  one-cycle pulse after the last slot (volume) of each full pass
- all_valid  out  1  sticky; 1 after the first full pass with no timeouts
- timeout_err  out  1  sticky; 1 once any slot times out, cleared only by rst

Behaviour:
- Reset values (rst=1 on a clk edge):
  - all gains and volume = 12'h800 (unity)
  - strt_cnv=0, chnnl=CHNL_MAP[0], scan_done=0, all_valid=0, timeout_err=0
  - slot index=0, FSM=IDLE, gap counter=0
- Slot order: 0..5 = LP, B1, B2, B3, HP, VOL. ADC channel = CHNL_MAP[slot] = {1,0,4,2,3,7}. Slot index wraps 5 -> 0.
- FSM states:
  - IDLE: gap counter increments while en=1. When the count reaches SCAN_GAP-1 -> START, and the counter clears.
  - START: strt_cnv=1 for exactly one cycle; chnnl driven. -> WAIT.
  - WAIT: timeout counter runs.
    - cnv_cmplt=1 -> STORE.
    - Counter reaches TIMEOUT-1 with no cnv_cmplt -> set timeout_err, keep the old register value, -> ADV.
  - STORE: write the res captured on the cnv_cmplt cycle into the slot register (visible the cycle after STORE). -> ADV.
  - ADV: advance slot.
    - If slot was 5: pulse scan_done. Set all_valid if that pass had no timeout; a per-pass flag clears at slot 0.
    - -> IDLE.
- Latency:
  - strt_cnv rises SCAN_GAP+1 cycles after entering IDLE.
  - A gain register updates 2 cycles after cnv_cmplt.
- Simultaneous events:
  - cnv_cmplt on the same cycle the timeout count expires counts as a completion, not a timeout.
  - cnv_cmplt outside WAIT is ignored.
- en deassert:
  - Mid-slot: the slot completes (STORE or timeout); the FSM then parks in IDLE with the gap counter held at 0.
  - Reassert: restart the gap count from 0 at the same slot index.
- rst mid-conversion: the FSM returns to IDLE with slot 0 and registers back at 12'h800. A late cnv_cmplt arriving after reset is ignored, because the FSM is in IDLE.
- Registers are unsigned 12-bit. No arithmetic on the data path except the optional deadband compare.

Optional Feature:
- Macro: POT_DEADBAND_EN.
- Defined: in STORE the register is written only if abs(res - current) >= DEADBAND. The difference is computed 13-bit signed. This suppresses filter-coefficient churn from pot noise. The first pass after reset always writes regardless of the compare.
- Undefined: STORE writes unconditionally; the DEADBAND parameter is unused.

Decomposition:
- Package eq_pkg:
  - typedef enum slot_t {SLOT_LP, SLOT_B1, SLOT_B2, SLOT_B3, SLOT_HP, SLOT_VOL}
  - localparam CHNL_MAP array
  - localparam UNITY_GAIN = 12'h800
  - typedef enum seq_state_t {IDLE, START, WAIT, STORE, ADV}
- One sub-module: seq_timer, a shared loadable down-counter reused for the SCAN_GAP and TIMEOUT intervals. The register bank and FSM stay in the top.

Test Plan:
- Reset, then idle with en=0 for 5000 cycles -> strt_cnv never pulses; all outputs 12'h800; all_valid=0.
- en=1 with an A2D model returning res=12'h3A5 for every channel -> six strt_cnv pulses with chnnl 1,0,4,2,3,7. All six registers = 12'h3A5. One scan_done; all_valid=1.
- Model withholds cnv_cmplt on channel 4 -> WAIT exits after 4096 cycles; timeout_err=1; b2_gain stays 12'h800; the scan continues to channel 2; all_valid stays 0 that pass.
- Assert rst 10 cycles after the strt_cnv for channel 2, then the model fires cnv_cmplt -> registers return to 12'h800 and the late completion is ignored. The next strt_cnv has chnnl=1.
- With POT_DEADBAND_EN: after the first pass at 12'h400, present 12'h404 on the next pass -> registers stay 12'h400; present 12'h410 -> registers = 12'h410.
- Drive cnv_cmplt on exactly the cycle the timeout expires -> the value is stored and timeout_err stays 0.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer pot-scan sequencer.
// Slot order, ADC channel map, unity gain and FSM state encoding.
package eq_pkg;

    typedef enum logic [2:0] {
        SLOT_LP,
        SLOT_B1,
        SLOT_B2,
        SLOT_B3,
        SLOT_HP,
        SLOT_VOL
    } slot_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STORE,
        ADV
    } seq_state_t;

    localparam int NUM_SLOTS = 6;

    // Entry [i] is the ADC channel read for slot i (LP first).
    localparam logic [NUM_SLOTS-1:0][2:0] CHNL_MAP = {
        3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1
    };

    localparam logic [11:0] UNITY_GAIN = 12'h800;

    function automatic slot_t next_slot(input slot_t s);
        return (s == SLOT_VOL) ? SLOT_LP : slot_t'(3'(s) + 3'd1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the scan-gap and conversion-timeout
// intervals; zero flags the last cycle of the loaded interval.
module seq_timer #(
    parameter int          W       = 13,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pot_scan_sequencer.sv
// Round-robin ADC128S pot scanner feeding the EQ band gains and volume.
// Define POT_DEADBAND_EN to suppress register writes below DEADBAND LSBs.
module pot_scan_sequencer
    import eq_pkg::*;
#(
    parameter int SCAN_GAP = 1024,
    parameter int TIMEOUT  = 4096
`ifdef POT_DEADBAND_EN
    ,
    parameter int DEADBAND = 8
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] lp_gain,
    output logic [11:0] b1_gain,
    output logic [11:0] b2_gain,
    output logic [11:0] b3_gain,
    output logic [11:0] hp_gain,
    output logic [11:0] volume,
    output logic        scan_done,
    output logic        all_valid,
    output logic        timeout_err
);

    localparam int TMAX = (SCAN_GAP > TIMEOUT) ? SCAN_GAP : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] GAP_LD = TW'(SCAN_GAP - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);

    seq_state_t state_q, state_d;
    slot_t      slot_q;

    logic [NUM_SLOTS-1:0][11:0] gain_q;
    logic [11:0] res_q;
    logic        pass_to_q;
    logic        wr_ok;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_dec;
    logic          tmr_zero;
    logic          store_en;
    logic          to_hit;
    logic          adv;

    seq_timer #(
        .W       (TW),
        .RST_VAL (GAP_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = GAP_LD;
        tmr_dec   = 1'b0;
        strt_cnv  = 1'b0;
        scan_done = 1'b0;
        store_en  = 1'b0;
        to_hit    = 1'b0;
        adv       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Disabled: keep the gap count parked at its start.
                if (!en) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d = START;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            START: begin
                strt_cnv = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TO_LD;
                state_d  = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout expiring on the same cycle.
                if (cnv_cmplt) begin
                    state_d = STORE;
                end else if (tmr_zero) begin
                    to_hit  = 1'b1;
                    state_d = ADV;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            STORE: begin
                store_en = 1'b1;
                state_d  = ADV;
            end
            ADV: begin
                adv       = 1'b1;
                scan_done = (slot_q == SLOT_VOL);
                tmr_load  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= SLOT_LP;
        end else begin
            state_q <= state_d;
            if (adv) begin
                slot_q <= next_slot(slot_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (state_q == WAIT && cnv_cmplt) begin
            res_q <= res;
        end
    end

`ifdef POT_DEADBAND_EN
    logic               first_pass_q;
    logic signed [12:0] diff;
    logic [12:0]        mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_pass_q <= 1'b1;
        end else if (scan_done) begin
            first_pass_q <= 1'b0;
        end
    end

    always_comb begin
        diff  = $signed({1'b0, res_q}) - $signed({1'b0, gain_q[slot_q]});
        mag   = diff[12] ? 13'(-diff) : 13'(diff);
        wr_ok = first_pass_q || (mag >= 13'(DEADBAND));
    end
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gain_q <= {NUM_SLOTS{UNITY_GAIN}};
        end else if (store_en && wr_ok) begin
            gain_q[slot_q] <= res_q;
        end
    end

    // pass_to_q remembers a timeout anywhere in the current pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_to_q   <= 1'b0;
            all_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (to_hit) begin
                pass_to_q   <= 1'b1;
                timeout_err <= 1'b1;
            end else if (scan_done) begin
                pass_to_q <= 1'b0;
            end
            if (scan_done && !pass_to_q) begin
                all_valid <= 1'b1;
            end
        end
    end

    assign chnnl   = CHNL_MAP[slot_q];
    assign lp_gain = gain_q[SLOT_LP];
    assign b1_gain = gain_q[SLOT_B1];
    assign b2_gain = gain_q[SLOT_B2];
    assign b3_gain = gain_q[SLOT_B3];
    assign hp_gain = gain_q[SLOT_HP];
    assign volume  = gain_q[SLOT_VOL];

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// Scoreboard bench for pot_scan_sequencer with a behavioural A2D model.
// Expected channels, stores and pass results are queued, monitors compare.
module tb_pot_scan_sequencer;

    localparam int SCAN_GAP = 1024;
    localparam int TIMEOUT  = 4096;

    typedef struct packed {
        logic [5:0][11:0] g;
        logic             av;
        logic             te;
    } scan_rec_t;

    typedef struct packed {
        logic [2:0]  s;
        logic [11:0] v;
    } st_rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [11:0] lp_gain, b1_gain, b2_gain, b3_gain, hp_gain, volume;
    logic        scan_done, all_valid, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          ch_tbl [6] = '{1, 0, 4, 2, 3, 7};
    logic [11:0] exp_g [6];

    int          chq [$];
    scan_rec_t   scq [$];
    st_rec_t     stq [$];

    logic [11:0] res_val = 12'h000;
    logic [11:0] exp_val = 12'h000;
    int          hold_ch = -1;
    int          late_ch = -1;
    int          coinc_ch = -1;
    logic        cc_chk;

    pot_scan_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .cnv_cmplt   (cnv_cmplt),
        .res         (res),
        .lp_gain     (lp_gain),
        .b1_gain     (b1_gain),
        .b2_gain     (b2_gain),
        .b3_gain     (b3_gain),
        .hp_gain     (hp_gain),
        .volume      (volume),
        .scan_done   (scan_done),
        .all_valid   (all_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic int ch2slot(input int ch);
        case (ch)
            1: return 0;
            0: return 1;
            4: return 2;
            2: return 3;
            3: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [11:0] gain_of(input int s);
        case (s)
            0: return lp_gain;
            1: return b1_gain;
            2: return b2_gain;
            3: return b3_gain;
            4: return hp_gain;
            default: return volume;
        endcase
    endfunction

    // A2D model: answers strt_cnv after a channel-dependent delay.
    initial begin
        int ch;
        int d;
        cnv_cmplt = 1'b0;
        cc_chk = 1'b0;
        res = 12'h000;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                ch = int'(chnnl);
                if (ch == hold_ch) continue;
                d = (ch == coinc_ch) ? TIMEOUT : (ch == late_ch) ? 30 : 5;
                repeat (d) @(posedge clk);
                #1;
                res = res_val;
                cnv_cmplt = 1'b1;
                cc_chk = (ch != late_ch);
                if (cc_chk) stq.push_back({3'(ch2slot(ch)), exp_val});
                @(posedge clk);
                #1;
                cnv_cmplt = 1'b0;
                cc_chk = 1'b0;
            end
        end
    end

    // Every strt_cnv must match the next expected channel.
    always begin
        @(negedge clk);
        if (strt_cnv) begin
            checks++;
            if (chq.size() == 0) begin
                errors++;
                $display("FAIL strt_unexpected: got chnnl %0d want none", chnnl);
            end else begin
                int w;
                w = chq.pop_front();
                if (int'(chnnl) != w) begin
                    errors++;
                    $display("FAIL strt_chnnl: got %0d want %0d", chnnl, w);
                end
            end
        end
    end

    // Register written by a completion is visible two cycles later.
    always begin
        logic p1, p2;
        p1 = 1'b0;
        p2 = 1'b0;
        forever begin
            @(negedge clk);
            if (p2) begin
                if (stq.size() == 0) begin
                    chk("store_queue", 32'(stq.size()), 1);
                end else begin
                    st_rec_t r;
                    r = stq.pop_front();
                    chk("store_value", gain_of(int'(r.s)), r.v);
                end
            end
            p2 = p1;
            p1 = cnv_cmplt && cc_chk;
        end
    end

    // End of pass: all registers, then sticky flags one cycle later.
    always begin
        @(negedge clk);
        if (scan_done) begin
            if (scq.size() == 0) begin
                chk("scan_unexpected", 32'(scan_done), 0);
            end else begin
                scan_rec_t r;
                r = scq.pop_front();
                for (int s = 0; s < 6; s++) chk("pass_gain", gain_of(s), r.g[s]);
                @(negedge clk);
                chk("scan_done_width", 32'(scan_done), 0);
                chk("all_valid", 32'(all_valid), 32'(r.av));
                chk("timeout_err", 32'(timeout_err), 32'(r.te));
            end
        end
    end

    task automatic wait_strt(input int ch, output int t);
        bit found;
        found = 0;
        t = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (strt_cnv && int'(chnnl) == ch) begin
                found = 1;
                t = cyc;
            end
        end
        if (!found) chk("wait_strt_expired", 32'(ch), 32'hFFFF);
    endtask

    task automatic run_pass(input logic [11:0] v, input logic [11:0] ev,
                            input int hold, input logic av, input logic te);
        scan_rec_t r;
        bit        found;
        int        t0, t1;
        res_val = v;
        exp_val = ev;
        hold_ch = hold;
        for (int s = 0; s < 6; s++) begin
            chq.push_back(ch_tbl[s]);
            if (ch_tbl[s] != hold) exp_g[s] = ev;
            r.g[s] = exp_g[s];
        end
        r.av = av;
        r.te = te;
        scq.push_back(r);
        if (hold >= 0) begin
            wait_strt(hold, t0);
            wait_strt(ch_tbl[ch2slot(hold) + 1], t1);
            checks++;
            if (t1 - t0 < TIMEOUT + SCAN_GAP + 1 ||
                t1 - t0 > TIMEOUT + SCAN_GAP + 4) begin
                errors++;
                $display("FAIL timeout_interval: got %0d want %0d..%0d",
                         t1 - t0, TIMEOUT + SCAN_GAP + 1, TIMEOUT + SCAN_GAP + 4);
            end
        end
        found = 0;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge clk);
            if (scan_done) found = 1;
        end
        if (!found) chk("scan_done_expired", 32'(scan_done), 1);
        repeat (3) @(negedge clk);
        hold_ch = -1;
    endtask

    task automatic check_unity(input string nm);
        for (int s = 0; s < 6; s++) chk(nm, gain_of(s), 12'h800);
    endtask

    initial begin
        int n;
        int t;
        for (int s = 0; s < 6; s++) exp_g[s] = 12'h800;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Disabled: no conversions, reset values hold.
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (strt_cnv) n++;
        end
        chk("idle_strt_count", 32'(n), 0);
        check_unity("idle_gain");
        chk("idle_all_valid", 32'(all_valid), 0);
        chk("idle_timeout_err", 32'(timeout_err), 0);
        chk("idle_chnnl", 32'(chnnl), 1);
        chk("idle_scan_done", 32'(scan_done), 0);

        // Full clean pass.
        en = 1'b1;
        run_pass(12'h3A5, 12'h3A5, -1, 1'b1, 1'b0);

        // Fresh reset, channel 4 never answers.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 6; s++) exp_g[s] = 12'h800;
        run_pass(12'h155, 12'h155, 4, 1'b0, 1'b1);

        // Reset while channel 2 is converting; its completion arrives late.
        late_ch = 2;
        res_val = 12'h155;
        exp_val = 12'h155;
        for (int s = 0; s < 6; s++) chq.push_back(ch_tbl[s]);
        wait_strt(2, t);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chq.delete();
        repeat (40) @(negedge clk);
        late_ch = -1;
        check_unity("post_rst_gain");
        chk("post_rst_timeout_err", 32'(timeout_err), 0);
        chk("post_rst_all_valid", 32'(all_valid), 0);
        chk("post_rst_chnnl", 32'(chnnl), 1);
        for (int s = 0; s < 6; s++) exp_g[s] = 12'h800;

        // LP completes on the very cycle its timeout expires.
        coinc_ch = 1;
        run_pass(12'h2C7, 12'h2C7, -1, 1'b1, 1'b0);
        coinc_ch = -1;

`ifdef POT_DEADBAND_EN
        run_pass(12'h400, 12'h400, -1, 1'b1, 1'b0);
        run_pass(12'h404, 12'h400, -1, 1'b1, 1'b0);
        run_pass(12'h410, 12'h410, -1, 1'b1, 1'b0);
`endif

        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("chq_drained", 32'(chq.size()), 0);
        chk("scq_drained", 32'(scq.size()), 0);
        chk("stq_drained", 32'(stq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
